regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single write port of reg_file_8x16 between two writeback sources:
//  requester 0 (ALU result) and requester 1 (memory/load result). Each requester
//  owns a one-entry holding slot with a valid/ready handshake. A round-robin
//  arbiter drains the slots into registered wr_en/wr0_addr/wr0_data outputs,
//  which connect directly to the register file.
// PARAMETERS
//  DATA_W  16  write data width; must match the register file word
//  ADDR_W  3   register address width (8 registers)
//  CNT_W   16  width of the committed-write counter
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req0_valid in   1       requester 0 has a write
//  req0_addr  in   ADDR_W  requester 0 destination register
//  req0_data  in   DATA_W  requester 0 write data
//  req0_ready out  1       requester 0 slot can accept this cycle
//  req1_valid in   1       requester 1 has a write
//  req1_addr  in   ADDR_W  requester 1 destination register
//  req1_data  in   DATA_W  requester 1 write data
//  req1_ready out  1       requester 1 slot can accept this cycle
//  wr_en      out  1       to reg file wr_en (registered)
//  wr0_addr   out  ADDR_W  to reg file wr0_addr (registered)
//  wr0_data   out  DATA_W  to reg file wr0_data (registered)
//  busy       out  1       any slot valid or wr_en high
//  wr_count   out  CNT_W   number of writes issued (wr_en cycles); wraps
// BEHAVIOUR
//  - Reset (async, rst_n=0): slot0_v=slot1_v=0, wr_en=0, wr0_addr=0, wr0_data=0,
//    wr_count=0, last_grant=1 (requester 0 wins the first tie). Pending slot
//    contents are discarded; a reset mid-operation loses buffered writes.
//  - Handshake: a transfer occurs on a rising edge when reqN_valid && reqN_ready.
//    reqN_ready = !slotN_v || grantN (slot freed this edge may refill this edge).
//    ready does not depend on valid. Requesters hold addr/data stable while
//    valid && !ready.
//  - Arbitration (combinational from slot valids):
//    only slot0_v -> grant0; only slot1_v -> grant1; neither -> no grant;
//    both -> grant the requester != last_grant. last_grant updates on each grant.
//  - Output stage, every edge: wr_en <= grant0|grant1; when granted,
//    wr0_addr/wr0_data <= granted slot addr/data, else they hold their values.
//  - Latency: accepted at edge k -> earliest wr_en=1 after edge k+1 -> register
//    file commits at edge k+2. A continuously valid single requester sustains
//    one write per cycle (full throughput).
//  - Both requesters streaming: writes alternate 0,1,0,1,...; each slot drains
//    every 2 cycles, so each ready is high on alternate cycles.
//  - Same destination in both slots: both are written, in grant order; the
//    register holds the data of the later grant. No merging or dropping.
//  - wr_count increments by 1 on each edge where the registered wr_en is 1;
//    wraps 2^CNT_W-1 -> 0.
//  - busy = slot0_v | slot1_v | wr_en.
// TESTING
//  1 Reset: rst_n=0 mid-stream with both slots full -> wr_en=0, readys=1,
//    wr_count=0 immediately; no write to reg file after release.
//  2 Single source: req0 writes r3=0x1234 at edge k -> wr_en=1, addr=3,
//    data=0x1234 after edge k+1; reading r3 afterwards returns 0x1234.
//  3 Contention: both valid from reset, req0 r1=0xAAAA, req1 r2=0x5555
//    -> wr_en cycles show r1 then r2; then alternation holds for 8 writes.
//  4 Collision: both target r5 (0x0001 req0, 0x0002 req1) same cycle from
//    reset -> r5 reads 0x0002; wr_count +2.
//  5 Backpressure: req1 held valid for 10 cycles while req0 streams ->
//    req1 addr/data never lost or duplicated; scoreboard matches reg file
//    contents for all 8 registers.
//  6 Counter wrap: CNT_W=4, 17 writes -> wr_count=1.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between an
// ALU writeback source (requester 0) and a load writeback source (requester 1).
module regfile_wr_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [DATA_W-1:0] wr0_data,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              slot0_v;
    logic [ADDR_W-1:0] slot0_addr;
    logic [DATA_W-1:0] slot0_data;
    logic              slot1_v;
    logic [ADDR_W-1:0] slot1_addr;
    logic [DATA_W-1:0] slot1_data;
    logic              last_grant;
    logic              grant0;
    logic              grant1;

    // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (slot0_v && slot1_v) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = slot0_v;
            grant1 = slot1_v;
        end
    end

    // Handshake: a write transfers on a rising edge when valid && ready. Ready is
    // independent of valid and is also high when the slot drains on the same edge,
    // so a requester can refill its slot every cycle. While valid && !ready the
    // requester holds addr/data stable.
    assign req0_ready = !slot0_v || grant0;
    assign req1_ready = !slot1_v || grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_v    <= 1'b0;
            slot0_addr <= '0;
            slot0_data <= '0;
        end else if (req0_valid && req0_ready) begin
            slot0_v    <= 1'b1;
            slot0_addr <= req0_addr;
            slot0_data <= req0_data;
        end else if (grant0) begin
            slot0_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot1_v    <= 1'b0;
            slot1_addr <= '0;
            slot1_data <= '0;
        end else if (req1_valid && req1_ready) begin
            slot1_v    <= 1'b1;
            slot1_addr <= req1_addr;
            slot1_data <= req1_data;
        end else if (grant1) begin
            slot1_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Address/data hold their last value on idle cycles; only wr_en qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr0_addr <= '0;
            wr0_data <= '0;
        end else begin
            wr_en <= grant0 | grant1;
            if (grant0) begin
                wr0_addr <= slot0_addr;
                wr0_data <= slot0_data;
            end else if (grant1) begin
                wr0_addr <= slot1_addr;
                wr0_data <= slot1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_en) begin
            wr_count <= wr_count + CNT_ONE;
        end
    end

    assign busy = slot0_v | slot1_v | wr_en;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: behavioural register file, write-order
// scoreboard and a second instance with a 4-bit counter for the wrap case.
module tb_regfile_wr_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              busy;
  logic [15:0]       wr_count;

  logic              w_req0_ready;
  logic              w_req1_ready;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr0_addr;
  logic [DATA_W-1:0] w_wr0_data;
  logic              w_busy;
  logic [3:0]        w_wr_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]      src0_q[$];
  logic [W-1:0]      src1_q[$];
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] rf[8];
  logic [DATA_W-1:0] exp_rf[8];

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .busy(busy), .wr_count(wr_count)
  );

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(w_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(w_req1_ready),
    .wr_en(w_wr_en), .wr0_addr(w_wr0_addr), .wr0_data(w_wr0_data), .busy(w_busy), .wr_count(w_wr_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural register file fed by the arbiter outputs
  always @(posedge clk) begin
    if (wr_en) rf[wr0_addr] <= wr0_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_valid = (src0_q.size() != 0);
    req1_valid = (src1_q.size() != 0);
    {req0_addr, req0_data} = req0_valid ? src0_q[0] : '0;
    {req1_addr, req1_data} = req1_valid ? src1_q[0] : '0;
  endtask

  // one clock: transfer bookkeeping, then scoreboard on any issued write
  task automatic step();
    logic fire0;
    logic fire1;
    logic [W-1:0] exp_w;
    fire0 = req0_valid && req0_ready;
    fire1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (fire0) void'(src0_q.pop_front());
    if (fire1) void'(src1_q.pop_front());
    drive();
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {13'd0, wr0_addr, wr0_data}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("write_order", {13'd0, wr0_addr, wr0_data}, {13'd0, exp_w});
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    drive();
    for (int i = 0; i < 8; i++) rf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((busy || req0_valid || req1_valid) && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    drive();

    // reset mid-stream with both slots full
    do_reset();
    src0_q.push_back({3'd1, 16'h1111});
    src0_q.push_back({3'd2, 16'h2222});
    src1_q.push_back({3'd3, 16'h3333});
    src1_q.push_back({3'd4, 16'h4444});
    exp_q.push_back({3'd1, 16'h1111});
    drive();
    step();
    step();
    check("t1_wr_before_reset", {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0;
    src0_q.delete();
    src1_q.delete();
    drive();
    #1;
    check("t1_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("t1_rst_ready0", {31'd0, req0_ready}, 32'd1);
    check("t1_rst_ready1", {31'd0, req1_ready}, 32'd1);
    check("t1_rst_count", {16'd0, wr_count}, 32'd0);
    check("t1_rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("t1_count_after", {16'd0, wr_count}, 32'd0);
    check("t1_r1_untouched", {16'd0, rf[1]}, 32'd0);
    check("t1_r3_untouched", {16'd0, rf[3]}, 32'd0);

    // single source, latency
    do_reset();
    src0_q.push_back({3'd3, 16'h1234});
    exp_q.push_back({3'd3, 16'h1234});
    drive();
    check("t2_ready0", {31'd0, req0_ready}, 32'd1);
    step();
    check("t2_wr_en_k", {31'd0, wr_en}, 32'd0);
    step();
    check("t2_wr_en_k1", {31'd0, wr_en}, 32'd1);
    check("t2_addr", {29'd0, wr0_addr}, 32'd3);
    check("t2_data", {16'd0, wr0_data}, 32'h1234);
    step();
    check("t2_wr_en_k2", {31'd0, wr_en}, 32'd0);
    check("t2_count", {16'd0, wr_count}, 32'd1);
    check("t2_r3", {16'd0, rf[3]}, 32'h1234);

    // contention, alternation over 8 writes
    do_reset();
    src0_q = '{{3'd1, 16'hAAAA}, {3'd3, 16'hA003}, {3'd5, 16'hA005}, {3'd7, 16'hA007}};
    src1_q = '{{3'd2, 16'h5555}, {3'd4, 16'h5004}, {3'd6, 16'h5006}, {3'd0, 16'h5000}};
    exp_q  = '{{3'd1, 16'hAAAA}, {3'd2, 16'h5555}, {3'd3, 16'hA003}, {3'd4, 16'h5004},
               {3'd5, 16'hA005}, {3'd6, 16'h5006}, {3'd7, 16'hA007}, {3'd0, 16'h5000}};
    drive();
    step();
    check("t3_ready0_e1", {31'd0, req0_ready}, 32'd1);
    check("t3_ready1_e1", {31'd0, req1_ready}, 32'd0);
    step();
    check("t3_first_addr", {29'd0, wr0_addr}, 32'd1);
    check("t3_ready0_e2", {31'd0, req0_ready}, 32'd0);
    check("t3_ready1_e2", {31'd0, req1_ready}, 32'd1);
    step();
    check("t3_second_addr", {29'd0, wr0_addr}, 32'd2);
    wait_idle("t3_idle", 40);
    check("t3_all_written", exp_q.size(), 32'd0);
    check("t3_count", {16'd0, wr_count}, 32'd8);

    // collision on r5
    do_reset();
    src0_q.push_back({3'd5, 16'h0001});
    src1_q.push_back({3'd5, 16'h0002});
    exp_q = '{{3'd5, 16'h0001}, {3'd5, 16'h0002}};
    drive();
    wait_idle("t4_idle", 20);
    check("t4_all_written", exp_q.size(), 32'd0);
    check("t4_r5", {16'd0, rf[5]}, 32'h0002);
    check("t4_count", {16'd0, wr_count}, 32'd2);

    // req1 under backpressure while req0 streams
    do_reset();
    src0_q = '{{3'd0, 16'h0A00}, {3'd1, 16'h0A01}, {3'd2, 16'h0A02}, {3'd3, 16'h0A03},
               {3'd1, 16'h0A11}, {3'd7, 16'h0A07}};
    src1_q = '{{3'd4, 16'h0B04}, {3'd1, 16'h0B01}, {3'd5, 16'h0B05}, {3'd3, 16'h0B03}};
    exp_q  = '{{3'd0, 16'h0A00}, {3'd4, 16'h0B04}, {3'd1, 16'h0A01}, {3'd1, 16'h0B01},
               {3'd2, 16'h0A02}, {3'd5, 16'h0B05}, {3'd3, 16'h0A03}, {3'd3, 16'h0B03},
               {3'd1, 16'h0A11}, {3'd7, 16'h0A07}};
    exp_rf = '{16'h0A00, 16'h0A11, 16'h0A02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0000, 16'h0A07};
    drive();
    wait_idle("t5_idle", 40);
    check("t5_all_written", exp_q.size(), 32'd0);
    check("t5_count", {16'd0, wr_count}, 32'd10);
    for (int i = 0; i < 8; i++) check($sformatf("t5_r%0d", i), {16'd0, rf[i]}, {16'd0, exp_rf[i]});

    // counter wrap at CNT_W=4 with full-throughput single source
    do_reset();
    for (int i = 0; i < 17; i++) begin
      src0_q.push_back({3'(i % 8), 16'h0100 + 16'(i)});
      exp_q.push_back({3'(i % 8), 16'h0100 + 16'(i)});
    end
    drive();
    repeat (19) step();
    check("t6_wr_en_done", {31'd0, wr_en}, 32'd0);
    check("t6_count16", {16'd0, wr_count}, 32'd17);
    check("t6_count4_wrap", {28'd0, w_wr_count}, 32'd1);
    check("t6_all_written", exp_q.size(), 32'd0);
    check("t6_r0", {16'd0, rf[0]}, 32'h0110);
    check("t6_r7", {16'd0, rf[7]}, 32'h010F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
